// File: rtl/sram32_read_checker.sv
// sram32_read_checker: reads NUM_WORDS consecutive SRAM words and checks data == adr + DATA_OFFSET.
// Optional build macro SRAM32_ERRCOUNT_EN: read every word and report a saturating error count.
module sram32_read_checker #(
    parameter int unsigned NUM_WORDS   = 256,
    parameter logic [21:0] START_ADR   = 22'h000000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] DATA_OFFSET = 32'h00010000
) (
    input  logic        refclk,
    input  logic        rst_n,
    inout  wire  [31:0] sram_d,
    output logic        sram_oe_n,
    output logic [21:0] sram_adr,
    output logic        sim_success,
    output logic        sim_done,
    output logic [31:0] sim_report
);
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int IW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, READ, SAMPLE, DONE} state_t;

    state_t          state;
    logic [WCW-1:0]  wait_cnt;
    logic [IW-1:0]   idx;
    logic [31:0]     data_q;
    logic [31:0]     expected;
    logic            mismatch;
    logic            last_word;

    // Expected word uses the (already wrapped) 22-bit address currently on the bus.
    assign expected  = {10'b0, sram_adr} + DATA_OFFSET;
    assign mismatch  = (data_q !== expected);
    assign last_word = (idx == IDX_LAST);

`ifdef SRAM32_ERRCOUNT_EN
    logic [15:0] err_cnt;
    logic [15:0] err_cnt_nxt;

    always_comb begin
        err_cnt_nxt = err_cnt;
        if (mismatch && (err_cnt != 16'hFFFF))
            err_cnt_nxt = err_cnt + 16'd1;
    end
`endif

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sram_oe_n   <= 1'b1;
            sram_adr    <= START_ADR;
            sim_done    <= 1'b0;
            sim_success <= 1'b0;
            sim_report  <= 32'h0;
            wait_cnt    <= '0;
            idx         <= '0;
            data_q      <= 32'h0;
`ifdef SRAM32_ERRCOUNT_EN
            err_cnt     <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: state <= SETUP;
                SETUP: begin
                    sram_oe_n <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= READ;
                end
                READ: begin
                    // Capture on the edge that also releases oe_n, so the bus is sampled while enabled.
                    if (wait_cnt == WAIT_LAST) begin
                        data_q    <= sram_d;
                        sram_oe_n <= 1'b1;
                        state     <= SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
`ifdef SRAM32_ERRCOUNT_EN
                    err_cnt <= err_cnt_nxt;
                    if (last_word) begin
                        state    <= DONE;
                        sim_done <= 1'b1;
                        if (err_cnt_nxt == 16'h0) begin
                            sim_success <= 1'b1;
                            sim_report  <= data_q;
                        end else begin
                            sim_success <= 1'b0;
                            sim_report  <= {1'b1, 15'b0, err_cnt_nxt};
                        end
                    end else begin
                        sram_adr <= sram_adr + 22'd1;
                        idx      <= idx + 1'b1;
                        state    <= SETUP;
                    end
`else
                    if (mismatch) begin
                        state       <= DONE;
                        sim_done    <= 1'b1;
                        sim_success <= 1'b0;
                        sim_report  <= {1'b1, 9'b0, sram_adr};
                    end else if (last_word) begin
                        state       <= DONE;
                        sim_done    <= 1'b1;
                        sim_success <= 1'b1;
                        sim_report  <= data_q;
                    end else begin
                        sram_adr <= sram_adr + 22'd1;
                        idx      <= idx + 1'b1;
                        state    <= SETUP;
                    end
`endif
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram32_read_checker.sv
// Bench for sram32_read_checker: SRAM model, table of fault scenarios, scoreboard of final results,
// per-word address order and oe_n/address stability monitors, mid-run reset and address wrap runs.
module tb_sram32_read_checker;
    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic        rst_n   = 1'b0;
    logic        rst_w_n = 1'b0;
    wire  [31:0] sram_d, sram_d_w;
    logic        oe_n, oe_n_w;
    logic [21:0] adr, adr_w;
    logic        succ, succ_w, done, done_w;
    logic [31:0] rep, rep_w;

    logic        float_bus   = 1'b0;
    logic        corrupt_en  = 1'b0;
    logic [21:0] corrupt_adr = 22'h0;

    int checks = 0;
    int passes = 0;

    sram32_read_checker dut (
        .refclk(refclk), .rst_n(rst_n), .sram_d(sram_d), .sram_oe_n(oe_n), .sram_adr(adr),
        .sim_success(succ), .sim_done(done), .sim_report(rep)
    );

    sram32_read_checker #(.NUM_WORDS(4), .START_ADR(22'h3FFFFE)) dut_w (
        .refclk(refclk), .rst_n(rst_w_n), .sram_d(sram_d_w), .sram_oe_n(oe_n_w), .sram_adr(adr_w),
        .sim_success(succ_w), .sim_done(done_w), .sim_report(rep_w)
    );

    // SRAM models: drive the pattern only while output-enabled, optional single-word corruption.
    assign sram_d = (!oe_n && !float_bus) ?
        (({10'b0, adr} + 32'h00010000) ^ {31'b0, (corrupt_en && (adr == corrupt_adr))}) : 32'bz;
    assign sram_d_w = !oe_n_w ? ({10'b0, adr_w} + 32'h00010000) : 32'bz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passes++;
    endtask

    // Monitors: the DUT's view of reset at the last edge, address order, address stability.
    logic        rq = 1'b0, rq_w = 1'b0;
    logic        last_oe = 1'b1, last_oe_w = 1'b1;
    logic [21:0] last_adr = 22'h0, last_adr_w = 22'h0;
    logic [21:0] exp_adr = 22'h0, exp_adr_w = 22'h3FFFFE;
    int          viol = 0, viol_w = 0;

    always @(posedge refclk) begin
        rq   <= rst_n;
        rq_w <= rst_w_n;
    end

    always @(negedge refclk) begin
        if (!rq) exp_adr = 22'h0;
        else begin
            if ((!oe_n || !last_oe) && (adr != last_adr)) viol++;
            if (last_oe && !oe_n) begin
                check("adr_order", {10'b0, adr}, {10'b0, exp_adr});
                exp_adr = exp_adr + 22'd1;
            end
        end
        last_oe  = oe_n;
        last_adr = adr;
    end

    always @(negedge refclk) begin
        if (!rq_w) exp_adr_w = 22'h3FFFFE;
        else begin
            if ((!oe_n_w || !last_oe_w) && (adr_w != last_adr_w)) viol_w++;
            if (last_oe_w && !oe_n_w) begin
                check("wrap_adr_order", {10'b0, adr_w}, {10'b0, exp_adr_w});
                exp_adr_w = exp_adr_w + 22'd1;
            end
        end
        last_oe_w  = oe_n_w;
        last_adr_w = adr_w;
    end

    typedef struct {
        string       name;
        bit          float_bus;
        bit          corrupt_en;
        logic [21:0] corrupt_adr;
        logic [31:0] exp_report;
        bit          exp_success;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] report;
        bit          success;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input string n, input bit f, input bit c, input logic [21:0] ca,
                                input logic [31:0] r, input bit s, input int cy);
        vec_t v;
        v.name = n; v.float_bus = f; v.corrupt_en = c; v.corrupt_adr = ca;
        v.exp_report = r; v.exp_success = s; v.exp_cycles = cy;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_oe_n"}, {31'b0, oe_n}, 32'h1);
        check({tag, "_adr"}, {10'b0, adr}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
        check({tag, "_success"}, {31'b0, succ}, 32'h0);
        check({tag, "_report"}, rep, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge refclk);
        rst_n = 1'b0;
        @(posedge refclk); #1;
        check_reset_vals(tag);
        @(negedge refclk);
        viol  = 0;
        rst_n = 1'b1;
    endtask

    // Counts edges from reset release until sim_done, then scores against the queue head.
    task automatic run_and_score();
        int   cyc;
        exp_t e;
        cyc = 0;
        while (cyc < 2000 && !done) begin
            @(posedge refclk); #1;
            cyc++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'h1, 32'h0);
            return;
        end
        e = sb.pop_front();
        check({e.name, "_cycles"}, cyc, e.cycles);
        check({e.name, "_report"}, rep, e.report);
        check({e.name, "_success"}, {31'b0, succ}, {31'b0, e.success});
        repeat (4) @(posedge refclk);
        #1;
        check({e.name, "_sticky_done"}, {31'b0, done}, 32'h1);
        check({e.name, "_sticky_report"}, rep, e.report);
        check({e.name, "_idle_oe_n"}, {31'b0, oe_n}, 32'h1);
        check({e.name, "_adr_stable"}, viol, 32'h0);
    endtask

    initial begin
        vec_t tbl[5];
        exp_t e;
        int   cyc;

        tbl[0] = mk("pass", 0, 0, 22'h0, 32'h000100FF, 1, 1025);
`ifdef SRAM32_ERRCOUNT_EN
        tbl[1] = mk("corrupt5", 0, 1, 22'h05, 32'h80000001, 0, 1025);
        tbl[2] = mk("float", 1, 0, 22'h0, 32'h80000100, 0, 1025);
        tbl[3] = mk("corrupt0", 0, 1, 22'h00, 32'h80000001, 0, 1025);
        tbl[4] = mk("corruptFF", 0, 1, 22'hFF, 32'h80000001, 0, 1025);
`else
        tbl[1] = mk("corrupt5", 0, 1, 22'h05, 32'h80000005, 0, 25);
        tbl[2] = mk("float", 1, 0, 22'h0, 32'h80000000, 0, 5);
        tbl[3] = mk("corrupt0", 0, 1, 22'h00, 32'h80000000, 0, 5);
        tbl[4] = mk("corruptFF", 0, 1, 22'hFF, 32'h800000FF, 0, 1025);
`endif

        repeat (2) @(posedge refclk);

        for (int i = 0; i < 5; i++) begin
            float_bus   = tbl[i].float_bus;
            corrupt_en  = tbl[i].corrupt_en;
            corrupt_adr = tbl[i].corrupt_adr;
            do_reset({tbl[i].name, "_rst"});
            e.name = tbl[i].name; e.report = tbl[i].exp_report;
            e.success = tbl[i].exp_success; e.cycles = tbl[i].exp_cycles;
            sb.push_back(e);
            run_and_score();
        end

        // One-cycle reset in the middle of word 100, then a clean full run.
        float_bus  = 1'b0;
        corrupt_en = 1'b0;
        do_reset("midrst_pre");
        repeat (403) @(posedge refclk);
        #1;
        check("midrst_busy_done", {31'b0, done}, 32'h0);
        check("midrst_busy_adr", {10'b0, adr}, 32'd100);
        do_reset("midrst");
        e.name = "midrst_run"; e.report = 32'h000100FF; e.success = 1'b1; e.cycles = 1025;
        sb.push_back(e);
        run_and_score();

        // Address wrap across 22'h3FFFFF on the small instance.
        @(negedge refclk);
        rst_w_n = 1'b0;
        @(posedge refclk); #1;
        check("wrap_rst_adr", {10'b0, adr_w}, 32'h003FFFFE);
        check("wrap_rst_done", {31'b0, done_w}, 32'h0);
        @(negedge refclk);
        viol_w  = 0;
        rst_w_n = 1'b1;
        cyc = 0;
        while (cyc < 200 && !done_w) begin
            @(posedge refclk); #1;
            cyc++;
        end
        check("wrap_cycles", cyc, 32'd17);
        check("wrap_report", rep_w, 32'h00010001);
        check("wrap_success", {31'b0, succ_w}, 32'h1);
        check("wrap_final_adr", {10'b0, adr_w}, 32'h1);
        check("wrap_words_read", {10'b0, exp_adr_w}, 32'h2);
        check("wrap_adr_stable", viol_w, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
